// File: rtl/reg_file.sv
// rtl/reg_file.sv - four-entry register file with a registered, handshaked read port.
// REG_FILE_BYPASS_EN: a read that collides with a same-entry write returns wdata.
module reg_file #(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [1:0]      waddr,
  input  logic [size-1:0] wdata,
  input  logic            rd_req,
  input  logic [1:0]      raddr,
  output logic            rd_req_rdy,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [size-1:0] rd_data,
  output logic [7:0]      rd_count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]      state;
  logic [size-1:0] mem [4];
  logic            accept;
  logic            handshake;
  logic [size-1:0] read_value;

  assign rd_valid   = (state == HOLD);
  assign handshake  = rd_valid & rd_ready;
  assign rd_req_rdy = (state == IDLE) | handshake;
  assign accept     = rd_req & rd_req_rdy;

`ifdef REG_FILE_BYPASS_EN
  assign read_value = (we && (waddr == raddr)) ? wdata : mem[raddr];
`else
  assign read_value = mem[raddr];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // rd_data only loads on acceptance, so it holds through stalls and after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_data  <= '0;
      rd_count <= '0;
    end else begin
      if (accept) begin
        state   <= HOLD;
        rd_data <= read_value;
      end else if (handshake) begin
        state <= IDLE;
      end
      if (handshake) begin
        rd_count <= rd_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - randomized and directed bench for reg_file against a reference model.
module tb_reg_file;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [1:0] waddr;
  logic [3:0] wdata;
  logic       rd_req;
  logic [1:0] raddr;
  logic       rd_req_rdy;
  logic       rd_valid;
  logic       rd_ready;
  logic [3:0] rd_data;
  logic [7:0] rd_count;

  int tests = 0;
  int fails = 0;

  // Reference model: storage contents, whether a read result is pending, its data, the count.
  int m_mem [4];
  bit m_pending;
  int m_data;
  int m_count;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_file #(.size(4)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .rd_req(rd_req), .raddr(raddr), .rd_req_rdy(rd_req_rdy), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_count(rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = 0;
    m_pending = 1'b0;
    m_data    = 0;
    m_count   = 0;
  endtask

  // Called just after a falling edge; applies one cycle of stimulus and checks the result.
  task automatic step(input bit w, input int wa, input int wd, input bit rq, input int ra, input bit rr);
    bit can_take;
    bit take;
    bit done;
    we = w; waddr = 2'(wa); wdata = 4'(wd);
    rd_req = rq; raddr = 2'(ra); rd_ready = rr;
    can_take = !m_pending || rr;
    #1;
    check("rd_req_rdy", 32'(rd_req_rdy), 32'(can_take));
    @(posedge clk);
    take = rq && can_take;
    done = m_pending && rr;
    if (done) m_count = (m_count + 1) % 256;
    if (take) begin
      m_data    = (BYPASS && w && (wa == ra)) ? wd : m_mem[ra];
      m_pending = 1'b1;
    end else if (done) begin
      m_pending = 1'b0;
    end
    if (w) m_mem[wa] = wd;
    @(negedge clk);
    check("rd_valid", 32'(rd_valid), 32'(m_pending));
    check("rd_data", 32'(rd_data), 32'(m_data));
    check("rd_count", 32'(rd_count), 32'(m_count));
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_count", 32'(rd_count), 32'd0);
    check("rst_rdy", 32'(rd_req_rdy), 32'd1);
    @(negedge clk);
    check("rst_hold_valid", 32'(rd_valid), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    rd_req = 1'b0; raddr = '0; rd_ready = 1'b0;
    model_reset();
    #1;
    check("por_valid", 32'(rd_valid), 32'd0);
    check("por_rdy", 32'(rd_req_rdy), 32'd1);
    @(negedge clk);
    check("por_count", 32'(rd_count), 32'd0);
    rst_n = 1'b1;

    // Basic write then read, first edge after reset release.
    step(1, 2, 4'hA, 0, 0, 0);
    step(0, 0, 0, 1, 2, 1);
    check("basic_valid", 32'(rd_valid), 32'd1);
    check("basic_data", 32'(rd_data), 32'hA);
    step(0, 0, 0, 0, 0, 1);
    check("basic_count", 32'(rd_count), 32'd1);

    // Stall with rd_ready low while the captured entry is overwritten.
    step(1, 1, 4'h3, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 4'hF, 1, 2, 0);
      check("stall_data", 32'(rd_data), 32'h3);
      check("stall_count", 32'(rd_count), 32'd1);
    end
    step(0, 0, 0, 0, 0, 1);
    check("stall_release_count", 32'(rd_count), 32'd2);

    // Back-to-back reads with no bubble.
    for (int i = 0; i < 4; i++) step(1, i, i + 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, i, 1);
      check("b2b_valid", 32'(rd_valid), 32'd1);
      check("b2b_data", 32'(rd_data), 32'(i + 1));
    end
    step(0, 0, 0, 0, 0, 1);
    check("b2b_count", 32'(rd_count), 32'd6);

    // Same-entry write/read collision.
    step(1, 0, 4'h9, 0, 0, 0);
    step(1, 0, 4'h5, 1, 0, 0);
    check("collide_data", 32'(rd_data), BYPASS ? 32'h5 : 32'h9);
    step(0, 0, 0, 1, 0, 1);
    check("collide_after", 32'(rd_data), 32'h5);
    step(0, 0, 0, 0, 0, 1);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset();
      end else begin
        step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
             bit'($urandom_range(0, 2) != 0), int'($urandom_range(0, 3)), bit'($urandom_range(0, 3) != 0));
      end
    end
    step(0, 0, 0, 0, 0, 1);

    // Counter wrap after 256 handshakes, then reset while a result is held.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, i, 4'hC - i, 0, 0, 0);
    for (int i = 0; i < 257; i++) step(0, 0, 0, 1, int'($urandom_range(0, 3)), 1);
    check("wrap_count", 32'(rd_count), 32'd0);
    check("wrap_valid", 32'(rd_valid), 32'd1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, i, 1);
      check("post_rst_entry", 32'(rd_data), 32'd0);
    end
    step(0, 0, 0, 0, 0, 1);
    check("post_rst_count", 32'(rd_count), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter: size, default 4, data width in bits of each entry, of wdata and of rd_data.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: we  input  1  write enable.
REQ-005 Port: waddr  input  2  write entry index, 0-3.
REQ-006 Port: wdata  input  size  write data.
REQ-007 Port: rd_req  input  1  read request; qualified by rd_req_rdy.
REQ-008 Port: raddr  input  2  read entry index; sampled only in the cycle the request is accepted.
REQ-009 Port: rd_req_rdy  output  1  block can accept a read request this cycle.
REQ-010 Port: rd_valid  output  1  rd_data holds a completed read.
REQ-011 Port: rd_ready  input  1  consumer accepts rd_data.
REQ-012 Port: rd_data  output  size  registered read data.
REQ-013 Port: rd_count  output  8  count of completed read handshakes.

Function
REQ-014 Storage SHALL be 4 entries of size bits, written on the clock edge when we=1: entry[waddr] <= wdata.
REQ-015 The read FSM SHALL have two states:
- IDLE: rd_valid=0.
- HOLD: rd_valid=1.
REQ-016 rd_req_rdy SHALL equal (state==IDLE) | (rd_valid & rd_ready), combinationally.
REQ-017 A read SHALL be accepted on an edge where rd_req=1 and rd_req_rdy=1.
- On acceptance, rd_data SHALL load entry[raddr] and the state SHALL become HOLD.
- Latency: exactly one cycle from acceptance to rd_valid=1.
REQ-018 In HOLD with rd_ready=0, rd_data and rd_valid SHALL remain stable; writes to any entry, including the captured one, SHALL NOT alter rd_data.
REQ-019 In HOLD with rd_ready=1 (handshake):
- with rd_req=1, the next read SHALL be accepted on the same edge, with no idle bubble;
- otherwise the state SHALL return to IDLE.
- In both cases rd_data SHALL keep its last value.
REQ-020 rd_count SHALL increment by 1 on each handshake edge (rd_valid & rd_ready) and SHALL wrap from 255 to 0.
REQ-021 rd_req in IDLE with rd_req=0, or in HOLD with rd_ready=0, SHALL be ignored with no state change.
REQ-022 Simultaneous write and accepted read to the same entry SHALL follow REQ-030/REQ-031. The stored entry SHALL always take wdata.
REQ-023 Simultaneous writes and reads to different entries SHALL NOT interact.

Reset
REQ-024 While rst_n=0, regardless of clk:
- all four entries SHALL be 0;
- rd_data SHALL be 0;
- rd_valid SHALL be 0;
- rd_count SHALL be 0;
- the state SHALL be IDLE.
REQ-025 rd_req_rdy SHALL be 1 during and immediately after reset.
REQ-026 Reset asserted in HOLD SHALL drop rd_valid at once. The pending read SHALL be discarded and SHALL NOT be counted.
REQ-027 The first edge after rst_n rises SHALL operate normally; no extra wait cycles.

Configuration
REQ-028 The macro REG_FILE_BYPASS_EN SHALL select write-to-read bypass.
REQ-029 The macro SHALL affect only the same-entry collision case of REQ-022.
REQ-030 With REG_FILE_BYPASS_EN defined, a read accepted on the same edge as a write to the same entry SHALL return wdata.
REQ-031 With REG_FILE_BYPASS_EN undefined, that read SHALL return the entry value from before the write.

Verification
REQ-032 Reset, then write entry 2=4'hA; read raddr=2 with rd_ready=1 -> rd_valid=1 with rd_data=4'hA one cycle after acceptance; rd_count=1.
REQ-033 Read entry 1 (value 4'h3) with rd_ready=0 for 5 cycles while writing entry 1=4'hF -> rd_data stays 4'h3; rd_req_rdy=0; rd_count unchanged until rd_ready=1.
REQ-034 rd_req=1 and rd_ready=1 held; raddr cycles 0,1,2,3 with entries 1,2,3,4 -> rd_valid stays 1 for 4 consecutive cycles with data 1,2,3,4; rd_count increases by 4.
REQ-035 Write entry 0=4'h5 and accept a read of raddr=0 on the same edge (old value 4'h9) -> rd_data=4'h5 if REG_FILE_BYPASS_EN is defined, else 4'h9; entry 0 reads 4'h5 afterwards in both builds.
REQ-036 Perform 256 handshakes -> rd_count wraps to 0; then assert rst_n=0 mid-HOLD -> rd_valid=0 and rd_data=0 immediately, all entries read 0 after release.
